// File: rtl/tinysnn_pkg.sv
// Shared constants and helpers for the tinysnn LIF neuron array.
// The refractory logic is only built when TINYSNN_REFRAC_EN is defined.
package tinysnn_pkg;

  localparam int N_CH_DEF    = 4;
  localparam int IN_W_DEF    = 8;
  localparam int MEM_W_DEF   = 10;
  localparam int LEAK_SH_DEF = 3;
  localparam int REFRAC_DEF  = 4;

  // Refractory counter width; holds REFRAC values 0..15
  localparam int RC_W = 4;

  // Largest unsigned value representable in w bits (membrane saturation point)
  function automatic int sat_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/lif_channel.sv
// One leaky integrate-and-fire neuron: saturating membrane, shift leak,
// one-cycle spike. Refractory counter present only with TINYSNN_REFRAC_EN.
module lif_channel
  import tinysnn_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int MEM_W   = MEM_W_DEF,
  parameter int LEAK_SH = LEAK_SH_DEF,
  parameter int REFRAC  = REFRAC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd,
  input  logic [IN_W-1:0]  cur,
  input  logic [MEM_W-1:0] thresh,
  output logic             fire_next,
  output logic             spike,
  output logic [MEM_W-1:0] mem
);

  localparam logic [MEM_W-1:0] MEM_MAX = MEM_W'(sat_max(MEM_W));

  if (MEM_W <= IN_W) begin : g_bad_mem_w
    $error("lif_channel: MEM_W must exceed IN_W");
  end
  if (LEAK_SH < 1 || LEAK_SH > MEM_W - 1) begin : g_bad_leak_sh
    $error("lif_channel: LEAK_SH out of range");
  end
  if (REFRAC < 0 || REFRAC > 15) begin : g_bad_refrac
    $error("lif_channel: REFRAC out of range");
  end

  // Clamp an (MEM_W+1)-bit sum to the membrane range instead of wrapping
  function automatic logic [MEM_W-1:0] sat_mem(input logic [MEM_W:0] s);
    return s[MEM_W] ? MEM_MAX : s[MEM_W-1:0];
  endfunction

  logic [MEM_W-1:0] mem_p1;
  logic             spike_p1;
  logic             in_refrac;
  logic [MEM_W:0]   sum_p0;
  logic [MEM_W-1:0] mem_sat_p0;

`ifdef TINYSNN_REFRAC_EN
  logic [RC_W-1:0] rc_p1;

  assign in_refrac = (rc_p1 != '0);

  // Refractory countdown: loaded on a spike, decremented once per update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_p1 <= '0;
    end else if (upd) begin
      if (in_refrac) begin
        rc_p1 <= rc_p1 - 1'b1;
      end else if (fire_next) begin
        rc_p1 <= RC_W'(REFRAC);
      end
    end
  end
`else
  assign in_refrac = 1'b0;
`endif

  // Stage p0: leak, integrate, saturate and compare against threshold
  always_comb begin
    sum_p0     = {1'b0, mem_p1} - {1'b0, (mem_p1 >> LEAK_SH)} + {{(MEM_W + 1 - IN_W){1'b0}}, cur};
    mem_sat_p0 = sat_mem(sum_p0);
    fire_next  = upd && !in_refrac && (mem_sat_p0 >= thresh);
  end

  // Stage p1: membrane and spike registers; membrane is held at 0 while refractory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_p1   <= '0;
      spike_p1 <= 1'b0;
    end else begin
      spike_p1 <= fire_next;
      if (upd) begin
        if (in_refrac || fire_next) begin
          mem_p1 <= '0;
        end else begin
          mem_p1 <= mem_sat_p0;
        end
      end
    end
  end

  assign spike = spike_p1;
  assign mem   = mem_p1;

endmodule

// File: rtl/lif_neuron_array.sv
// Array of N_CH independent LIF neurons with a registered spike_any and a
// channel-0 membrane debug tap. Optional macro: TINYSNN_REFRAC_EN enables
// per-channel refractory periods of REFRAC updates after each spike.
module lif_neuron_array
  import tinysnn_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int IN_W    = IN_W_DEF,
  parameter int MEM_W   = MEM_W_DEF,
  parameter int LEAK_SH = LEAK_SH_DEF,
  parameter int REFRAC  = REFRAC_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [N_CH*IN_W-1:0] in_cur,
  input  logic [MEM_W-1:0]     thresh,
  output logic [N_CH-1:0]      spike,
  output logic                 spike_any,
  output logic [MEM_W-1:0]     mem_dbg
);

  if (N_CH < 1 || N_CH > 8) begin : g_bad_n_ch
    $error("lif_neuron_array: N_CH out of range");
  end

  logic                 upd;
  logic [N_CH-1:0]      fire_next;
  logic [MEM_W-1:0]     mem_ch [N_CH];
  logic                 spike_any_p1;

  assign upd = en & in_valid;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    lif_channel #(
      .IN_W    (IN_W),
      .MEM_W   (MEM_W),
      .LEAK_SH (LEAK_SH),
      .REFRAC  (REFRAC)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .upd       (upd),
      .cur       (in_cur[c*IN_W +: IN_W]),
      .thresh    (thresh),
      .fire_next (fire_next[c]),
      .spike     (spike[c]),
      .mem       (mem_ch[c])
    );
  end

  // Stage p1: spike_any registered alongside the per-channel spikes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_any_p1 <= 1'b0;
    end else begin
      spike_any_p1 <= |fire_next;
    end
  end

  assign spike_any = spike_any_p1;
  assign mem_dbg   = mem_ch[0];

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array (default parameters). Expected values
// depend on whether TINYSNN_REFRAC_EN is defined for the build.
module tb_lif_neuron_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_cur = '0;
  logic [9:0]  thresh = '0;
  logic [3:0]  spike;
  logic        spike_any;
  logic [9:0]  mem_dbg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [3:0] sp;
    logic [9:0] mem;
  } exp_t;

  exp_t q[$];

  lif_neuron_array dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_cur    (in_cur),
    .thresh    (thresh),
    .spike     (spike),
    .spike_any (spike_any),
    .mem_dbg   (mem_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue its expected outcome
  task automatic step(input string nm, input logic e, input logic v,
                      input logic [7:0] c3, input logic [7:0] c2,
                      input logic [7:0] c1, input logic [7:0] c0,
                      input logic [9:0] th, input logic [3:0] xsp, input logic [9:0] xmem);
    exp_t x;
    @(negedge clk);
    en       = e;
    in_valid = v;
    in_cur   = {c3, c2, c1, c0};
    thresh   = th;
    x.name = nm;
    x.sp   = xsp;
    x.mem  = xmem;
    q.push_back(x);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Assert reset between edges and check that outputs clear without a clock
  task automatic async_rst_check(input string nm);
    @(posedge clk);
    #3;
    en    = 1'b0;
    rst_n = 1'b0;
    #1;
    chk({nm, "_spike"}, 32'(spike), 0);
    chk({nm, "_any"}, 32'(spike_any), 0);
    chk({nm, "_mem"}, 32'(mem_dbg), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare outputs just after every rising edge that has a queued expectation
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk({x.name, "_spike"}, 32'(spike), 32'(x.sp));
        chk({x.name, "_any"}, 32'(spike_any), 32'(|x.sp));
        chk({x.name, "_mem"}, 32'(mem_dbg), 32'(x.mem));
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_spike", 32'(spike), 0);
    chk("reset_any", 32'(spike_any), 0);
    chk("reset_mem", 32'(mem_dbg), 0);
    rst_n = 1'b1;

    // Integrate to fire on ch0
    step("int1", 1, 1, 0, 0, 0, 30, 100, 4'b0000, 30);
    step("int2", 1, 1, 0, 0, 0, 30, 100, 4'b0000, 57);
    step("int3", 1, 1, 0, 0, 0, 30, 100, 4'b0000, 80);
    step("int4", 1, 1, 0, 0, 0, 30, 100, 4'b0001, 0);
`ifdef TINYSNN_REFRAC_EN
    step("ref1", 1, 1, 0, 0, 0, 30, 100, 4'b0000, 0);
    step("ref2", 1, 1, 0, 0, 0, 30, 100, 4'b0000, 0);
    step("ref3", 1, 1, 0, 0, 0, 30, 100, 4'b0000, 0);
    step("ref4", 1, 1, 0, 0, 0, 30, 100, 4'b0000, 0);
    step("ref5", 1, 1, 0, 0, 0, 30, 100, 4'b0000, 30);
`else
    step("ref1", 1, 1, 0, 0, 0, 30, 100, 4'b0000, 30);
    step("ref2", 1, 1, 0, 0, 0, 30, 100, 4'b0000, 57);
    step("ref3", 1, 1, 0, 0, 0, 30, 100, 4'b0000, 80);
    step("ref4", 1, 1, 0, 0, 0, 30, 100, 4'b0001, 0);
    step("ref5", 1, 1, 0, 0, 0, 30, 100, 4'b0000, 30);
`endif

    // Leak with zero input, then gating holds state
    step("pre1", 1, 1, 0, 0, 0, 30, 100, 4'b0000, 57);
    step("pre2", 1, 1, 0, 0, 0, 30, 100, 4'b0000, 80);
    step("leak1", 1, 1, 0, 0, 0, 0, 100, 4'b0000, 70);
    step("leak2", 1, 1, 0, 0, 0, 0, 100, 4'b0000, 62);
    step("leak3", 1, 1, 0, 0, 0, 0, 100, 4'b0000, 55);
    step("gate_en", 0, 1, 90, 90, 90, 90, 100, 4'b0000, 55);
    step("gate_vld", 1, 0, 90, 90, 90, 90, 100, 4'b0000, 55);
    step("gate_both", 0, 0, 90, 90, 90, 90, 100, 4'b0000, 55);
    step("leak4", 1, 1, 0, 0, 0, 0, 100, 4'b0000, 49);

    // Async reset mid-integration at mem 80
    rst_pulse();
    step("ar1", 1, 1, 0, 0, 0, 30, 100, 4'b0000, 30);
    step("ar2", 1, 1, 0, 0, 0, 30, 100, 4'b0000, 57);
    step("ar3", 1, 1, 0, 0, 0, 30, 100, 4'b0000, 80);
    async_rst_check("arst_mem80");

    // Saturation: never wraps, fires at full scale
    step("sat1", 1, 1, 0, 0, 0, 255, 1023, 4'b0000, 255);
    step("sat2", 1, 1, 0, 0, 0, 255, 1023, 4'b0000, 479);
    step("sat3", 1, 1, 0, 0, 0, 255, 1023, 4'b0000, 675);
    step("sat4", 1, 1, 0, 0, 0, 255, 1023, 4'b0000, 846);
    step("sat5", 1, 1, 0, 0, 0, 255, 1023, 4'b0000, 996);
    step("sat6", 1, 1, 0, 0, 0, 255, 1023, 4'b0001, 0);
    async_rst_check("arst_spike");

    // Independent channels and spike_any
    step("ind1", 1, 1, 0, 50, 100, 0, 100, 4'b0010, 0);
`ifdef TINYSNN_REFRAC_EN
    step("ind2", 1, 1, 0, 50, 100, 0, 100, 4'b0000, 0);
    step("ind3", 1, 1, 0, 50, 100, 0, 100, 4'b0100, 0);
`else
    step("ind2", 1, 1, 0, 50, 100, 0, 100, 4'b0010, 0);
    step("ind3", 1, 1, 0, 50, 100, 0, 100, 4'b0110, 0);
`endif

    // Zero threshold fires on every non-refractory update
    rst_pulse();
    step("th0_1", 1, 1, 0, 0, 0, 0, 0, 4'b1111, 0);
`ifdef TINYSNN_REFRAC_EN
    step("th0_2", 1, 1, 0, 0, 0, 0, 0, 4'b0000, 0);
`else
    step("th0_2", 1, 1, 0, 0, 0, 0, 0, 4'b1111, 0);
`endif
    step("idle", 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0);

    // Back-to-back firing on ch0 at threshold
    rst_pulse();
    step("b2b1", 1, 1, 0, 0, 0, 100, 100, 4'b0001, 0);
`ifdef TINYSNN_REFRAC_EN
    step("b2b2", 1, 1, 0, 0, 0, 100, 100, 4'b0000, 0);
    step("b2b3", 1, 1, 0, 0, 0, 100, 100, 4'b0000, 0);
`else
    step("b2b2", 1, 1, 0, 0, 0, 100, 100, 4'b0001, 0);
    step("b2b3", 1, 1, 0, 0, 0, 100, 100, 4'b0001, 0);
`endif
    step("tail", 0, 0, 0, 0, 0, 0, 100, 4'b0000, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
